// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Function : Round-robin sharing of one single-port word memory between an
//             instruction-fetch port and a load/store data port. Read
//             responses are registered; byte-enabled stores become a
//             two-cycle read-modify-write.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction-fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   // load/store data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   // memory side
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } state_t;

   localparam logic        c_PORT_INSTR = 1'b0;
   localparam logic        c_PORT_DATA  = 1'b1;
   localparam logic [29:0] c_WORDS      = 30'(WORDS);

   state_t      r_state;
   logic        r_rr_last;     // port that won the most recent grant
   logic [29:0] r_m_idx;       // read-modify-write word index
   logic [31:0] r_m_old;       // word as read in the grant cycle
   logic [31:0] r_m_wdata;
   logic [3:0]  r_m_be;

   logic        r_i_rvalid;
   logic [31:0] r_i_rdata;
   logic        r_i_err;
   logic        r_d_rvalid;
   logic [31:0] r_d_rdata;
   logic        r_d_err;

   logic        w_idle;
   logic        w_gnt_i;
   logic        w_gnt_d;
   logic        w_i_oor;
   logic        w_d_oor;
   logic        w_d_full;
   logic        w_d_part;
   logic [31:0] w_merged;
   logic [31:0] w_mem_addr;
   logic [31:0] w_mem_wdata;
   logic        w_mem_we;
   logic        w_unused;

   // Byte offsets are ignored; lanes are selected by d_be instead.
   assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

   assign w_i_oor  = (i_addr[31:2] >= c_WORDS);
   assign w_d_oor  = (d_addr[31:2] >= c_WORDS);
   assign w_d_full = d_we && (d_be == 4'b1111);
   assign w_d_part = d_we && (d_be != 4'b1111) && (d_be != 4'b0000);

   // Grants only in IDLE and outside reset; a tie goes to the port that did
   // not win last time.
   assign w_idle  = rst_n && (r_state == ST_IDLE);
   assign w_gnt_i = w_idle && i_req && (!d_req || (r_rr_last == c_PORT_DATA));
   assign w_gnt_d = w_idle && d_req && (!i_req || (r_rr_last == c_PORT_INSTR));

   // Merge the latched store lanes over the previously read word.
   always_comb begin
      w_merged = r_m_old;
      for (int b = 0; b < 4; b++) begin
         if (r_m_be[b]) begin
            w_merged[8*b +: 8] = r_m_wdata[8*b +: 8];
         end
      end
   end

   // Memory-side address/data/write-enable for the current cycle.
   always_comb begin
      w_mem_addr  = 32'h0;
      w_mem_wdata = 32'h0;
      w_mem_we    = 1'b0;
      if (rst_n && (r_state == ST_MERGE)) begin
         w_mem_addr  = {r_m_idx, 2'b00};
         w_mem_wdata = w_merged;
         w_mem_we    = 1'b1;
      end else if (w_gnt_i) begin
         w_mem_addr = {i_addr[31:2], 2'b00};
      end else if (w_gnt_d) begin
         w_mem_addr = {d_addr[31:2], 2'b00};
         if (w_d_full && !w_d_oor) begin
            w_mem_wdata = d_wdata;
            w_mem_we    = 1'b1;
         end
      end
   end

   // Control FSM, arbitration history and registered responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_rr_last  <= c_PORT_INSTR;
         r_m_idx    <= 30'h0;
         r_m_old    <= 32'h0;
         r_m_wdata  <= 32'h0;
         r_m_be     <= 4'h0;
         r_i_rvalid <= 1'b0;
         r_i_rdata  <= 32'h0;
         r_i_err    <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_d_rdata  <= 32'h0;
         r_d_err    <= 1'b0;
      end else begin
         r_i_rvalid <= 1'b0;
         r_i_err    <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_d_err    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_i) begin
                  r_rr_last  <= c_PORT_INSTR;
                  r_i_rvalid <= 1'b1;
                  r_i_err    <= w_i_oor;
                  r_i_rdata  <= w_i_oor ? 32'h0 : mem_read_data;
               end
               if (w_gnt_d) begin
                  r_rr_last <= c_PORT_DATA;
                  if (w_d_part && !w_d_oor) begin
                     // Old word is captured now and rewritten next cycle.
                     r_m_idx   <= d_addr[31:2];
                     r_m_old   <= mem_read_data;
                     r_m_wdata <= d_wdata;
                     r_m_be    <= d_be;
                     r_state   <= ST_MERGE;
                  end else begin
                     r_d_rvalid <= 1'b1;
                     r_d_err    <= w_d_oor;
                     r_d_rdata  <= (d_we || w_d_oor) ? 32'h0 : mem_read_data;
                  end
               end
            end
            ST_MERGE: begin
               r_d_rvalid <= 1'b1;
               r_d_rdata  <= 32'h0;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_gnt            = w_gnt_i;
   assign d_gnt            = w_gnt_d;
   assign i_rvalid         = r_i_rvalid;
   assign i_rdata          = r_i_rdata;
   assign i_err            = r_i_err;
   assign d_rvalid         = r_d_rvalid;
   assign d_rdata          = r_d_rdata;
   assign d_err            = r_d_err;
   assign mem_address      = w_mem_addr;
   assign mem_write_data   = w_mem_wdata;
   assign mem_write_enable = w_mem_we;

endmodule
`default_nettype wire
